// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute stage: opcode encodings, FSM state
// encodings and the bit positions of the {Z,N,C,V} flag vector.
// -----------------------------------------------------------------------------
package alu_pkg;

   // Opcode encodings
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // Execute-stage FSM states
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_MUL  = 2'b10,
      S_WB   = 2'b11
   } state_t;

   // Bit positions inside flags = {Z,N,C,V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_multiplier.sv
// -----------------------------------------------------------------------------
// alu_seq_multiplier
// Iterative shift-add multiplier, one partial product per clock, WIDTH
// iterations. Produces the low WIDTH bits of the unsigned product.
// Only compiled when the optional multiply (macro ALU_MUL_EN) is enabled.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high
//   start    one-cycle load strobe; captures op_a/op_b and clears the accumulator
//   op_a     multiplicand
//   op_b     multiplier
//   done     high during the final iteration cycle
//   product  accumulator value that results from the current iteration;
//            equals the final product while done is high
// -----------------------------------------------------------------------------
`ifdef ALU_MUL_EN
module alu_seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] acc_r;
   logic [CW-1:0]    count_r;
   logic             run_r;
   logic [WIDTH-1:0] acc_next_s;
   logic             last_s;

   // Accumulator update for this iteration and end-of-run detect
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
      last_s = run_r && (count_r == CW'(WIDTH - 1));
   end

   assign done    = last_s;
   assign product = acc_next_s;

   // Operand shift registers, accumulator and iteration counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         count_r  <= {CW{1'b0}};
         run_r    <= 1'b0;
      end else if (start) begin
         mcand_r  <= op_a;
         mplier_r <= op_b;
         acc_r    <= {WIDTH{1'b0}};
         count_r  <= {CW{1'b0}};
         run_r    <= 1'b1;
      end else if (run_r) begin
         acc_r    <= acc_next_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         if (last_s) begin
            count_r <= {CW{1'b0}};
            run_r   <= 1'b0;
         end else begin
            count_r <= count_r + CW'(1);
         end
      end
   end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle execute stage feeding the register file write port.
// ALU ops: IDLE -> EXEC -> WB. With macro ALU_MUL_EN, opcode 111 runs
// IDLE -> MUL (WIDTH cycles) -> WB on the shift-add multiplier; without it,
// opcode 111 produces a one-cycle illegal pulse in WB and no write-back.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start                 request, accepted only while idle
//   opcode, op_a, op_b    operation and operands (register file read ports)
//   dest                  destination register address
//   busy                  high while an operation is in flight
//   wb_en/wb_addr/wb_data one-cycle write-back to the register file
//   flags                 {Z,N,C,V} from the last write-back
//   illegal               one-cycle pulse for an unsupported opcode
// -----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        opcode,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic [ADDR_W-1:0] dest,
   output logic              busy,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [WIDTH-1:0]  wb_data,
   output logic [3:0]        flags,
   output logic              illegal
);

   localparam int SHW = $clog2(WIDTH);

   state_t            state_r;
   state_t            state_next_s;
   logic [2:0]        op_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [ADDR_W-1:0] dest_r;
   logic              busy_r;
   logic              wb_en_r;
   logic [ADDR_W-1:0] wb_addr_r;
   logic [WIDTH-1:0]  wb_data_r;
   logic [3:0]        flags_r;
   logic              illegal_r;
   logic              accept_s;
   logic [WIDTH:0]    sum_s;
   logic [WIDTH-1:0]  diff_s;
   logic [WIDTH-1:0]  alu_result_s;
   logic [3:0]        alu_flags_s;
   logic              carry_s;
   logic              ovf_s;

   assign accept_s = (state_r == S_IDLE) && start;

`ifdef ALU_MUL_EN
   logic             mul_start_s;
   logic             mul_done_s;
   logic [WIDTH-1:0] mul_product_s;
   logic [3:0]       mul_flags_s;

   assign mul_start_s = accept_s && (opcode == OP_MUL);

   alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clock   (clock),
      .reset   (reset),
      .start   (mul_start_s),
      .op_a    (op_a),
      .op_b    (op_b),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Multiply only reports Z and N; carry and overflow are always clear
   always_comb begin
      mul_flags_s         = 4'b0000;
      mul_flags_s[FLAG_Z] = (mul_product_s == {WIDTH{1'b0}});
      mul_flags_s[FLAG_N] = mul_product_s[WIDTH-1];
   end
`endif

   // Single-cycle ALU datapath on the latched operands
   always_comb begin
      sum_s        = {1'b0, a_r} + {1'b0, b_r};
      diff_s       = a_r - b_r;
      alu_result_s = {WIDTH{1'b0}};
      carry_s      = 1'b0;
      ovf_s        = 1'b0;
      case (op_r)
         OP_ADD: begin
            alu_result_s = sum_s[WIDTH-1:0];
            carry_s      = sum_s[WIDTH];
            // Overflow: like-signed operands giving an opposite-signed sum
            ovf_s        = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                           (sum_s[WIDTH-1] != a_r[WIDTH-1]);
         end
         OP_SUB: begin
            alu_result_s = diff_s;
            carry_s      = (a_r < b_r);
            // Overflow: unlike-signed operands, result sign differs from A
            ovf_s        = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                           (diff_s[WIDTH-1] != a_r[WIDTH-1]);
         end
         OP_AND:  alu_result_s = a_r & b_r;
         OP_OR:   alu_result_s = a_r | b_r;
         OP_XOR:  alu_result_s = a_r ^ b_r;
         OP_SLL:  alu_result_s = a_r << b_r[SHW-1:0];
         OP_SRL:  alu_result_s = a_r >> b_r[SHW-1:0];
         default: alu_result_s = {WIDTH{1'b0}};
      endcase
      alu_flags_s         = 4'b0000;
      alu_flags_s[FLAG_Z] = (alu_result_s == {WIDTH{1'b0}});
      alu_flags_s[FLAG_N] = alu_result_s[WIDTH-1];
      alu_flags_s[FLAG_C] = carry_s;
      alu_flags_s[FLAG_V] = ovf_s;
   end

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
`ifdef ALU_MUL_EN
               if (opcode == OP_MUL) begin
                  state_next_s = S_MUL;
               end else begin
                  state_next_s = S_EXEC;
               end
`else
               state_next_s = S_EXEC;
`endif
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_EXEC: state_next_s = S_WB;
`ifdef ALU_MUL_EN
         S_MUL: begin
            if (mul_done_s) begin
               state_next_s = S_WB;
            end else begin
               state_next_s = S_MUL;
            end
         end
`endif
         S_WB:    state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // Operand capture and registered outputs; write-back values are loaded on
   // the edge entering WB so they are stable for the whole WB cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_r      <= 3'b000;
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         dest_r    <= {ADDR_W{1'b0}};
         busy_r    <= 1'b0;
         wb_en_r   <= 1'b0;
         wb_addr_r <= {ADDR_W{1'b0}};
         wb_data_r <= {WIDTH{1'b0}};
         flags_r   <= 4'b0000;
         illegal_r <= 1'b0;
      end else begin
         busy_r    <= (state_next_s != S_IDLE);
         wb_en_r   <= 1'b0;
         illegal_r <= 1'b0;
         if (accept_s) begin
            op_r   <= opcode;
            a_r    <= op_a;
            b_r    <= op_b;
            dest_r <= dest;
         end
         if (state_r == S_EXEC) begin
            // Opcode 111 only reaches EXEC when the multiplier is absent
            if (op_r == OP_MUL) begin
               illegal_r <= 1'b1;
            end else begin
               wb_en_r   <= 1'b1;
               wb_addr_r <= dest_r;
               wb_data_r <= alu_result_s;
               flags_r   <= alu_flags_s;
            end
         end
`ifdef ALU_MUL_EN
         else if ((state_r == S_MUL) && mul_done_s) begin
            wb_en_r   <= 1'b1;
            wb_addr_r <= dest_r;
            wb_data_r <= mul_product_s;
            flags_r   <= mul_flags_s;
         end
`endif
      end
   end

   assign busy    = busy_r;
   assign wb_en   = wb_en_r;
   assign wb_addr = wb_addr_r;
   assign wb_data = wb_data_r;
   assign flags   = flags_r;
   assign illegal = illegal_r;

endmodule
